// File: rtl/polara_loopback_checker.sv
// ---------------------------------------------------------------------------
// polara_loopback_checker
//
// Receive-side checker for the Polara loopback packet generator. Parses the
// three chip-to-chipset NoC channels. Each header is compared against the
// expected loopback header. Saturating packet and error statistics are kept
// per channel and in aggregate. A registered, switch-selected view of those
// statistics drives the status outputs.
//
// Ports
//   chipset_clk              : sole clock
//   chipset_rst_n            : asynchronous active-low reset
//   chip_rst_n               : chip reset; while low the block is held in
//                              synchronous clear
//   clear                    : one-cycle synchronous statistics clear
//   sw_debounced[1:0]        : status view select (0..2 = noc1..3, 3 = aggregate)
//   intf_chipset_data_nocN   : incoming 64-bit flit, channel N
//   intf_chipset_val_nocN    : flit valid, channel N
//   intf_chipset_rdy_nocN    : flit ready, channel N (all equal en_q)
//   stat_pkt_count           : completed packets on the selected view
//   stat_err_count           : header errors on the selected view
//   stat_err_hdr             : most recent erroneous header on the selected view
//   err_flag[2:0]            : sticky per-channel error flag, bit 0 = noc1
//   alive                    : selected view completed a packet recently
// ---------------------------------------------------------------------------
module polara_loopback_checker #(
    parameter logic [13:0] EXP_CHIPID     = 14'b10000000000000,
    parameter logic [3:0]  EXP_FBITS      = 4'b0010,
    parameter logic [7:0]  EXP_MSG_TYPE   = 8'd18,
    parameter logic [7:0]  MAX_PAYLOAD    = 8'd8,
    parameter int          CNT_WIDTH      = 32,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                 chipset_clk,
    input  logic                 chipset_rst_n,
    input  logic                 chip_rst_n,
    input  logic                 clear,
    input  logic [1:0]           sw_debounced,
    input  logic [63:0]          intf_chipset_data_noc1,
    input  logic [63:0]          intf_chipset_data_noc2,
    input  logic [63:0]          intf_chipset_data_noc3,
    input  logic                 intf_chipset_val_noc1,
    input  logic                 intf_chipset_val_noc2,
    input  logic                 intf_chipset_val_noc3,
    output logic                 intf_chipset_rdy_noc1,
    output logic                 intf_chipset_rdy_noc2,
    output logic                 intf_chipset_rdy_noc3,
    output logic [CNT_WIDTH-1:0] stat_pkt_count,
    output logic [CNT_WIDTH-1:0] stat_err_count,
    output logic [63:0]          stat_err_hdr,
    output logic [2:0]           err_flag,
    output logic                 alive
);

    localparam int                   IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0]    IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    localparam logic [0:0] ST_HDR     = 1'b0;
    localparam logic [0:0] ST_PAYLOAD = 1'b1;

    // Saturating add of a small increment (0..3). Any overflow pins the
    // result at all-ones, including a multi-increment that crosses the top.
    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] a,
        input logic [1:0]           n
    );
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(n);
        return s[CNT_WIDTH] ? CNT_MAX : s[CNT_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Synchronous clear and flow-control enable
    // ------------------------------------------------------------------
    logic sclr;
    assign sclr = clear | ~chip_rst_n;

    // Two register stages: the enable condition is sampled into en_pre_reg
    // and then presented as en_q. Ready therefore rises on the second edge
    // after reset release. It drops one cycle after the FSMs are cleared.
    logic en_pre_reg;
    logic en_q;

    always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
        if (!chipset_rst_n) begin
            en_pre_reg <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            en_pre_reg <= chip_rst_n & ~clear;
            en_q       <= en_pre_reg;
        end
    end

    assign intf_chipset_rdy_noc1 = en_q;
    assign intf_chipset_rdy_noc2 = en_q;
    assign intf_chipset_rdy_noc3 = en_q;

    // ------------------------------------------------------------------
    // Channel input gathering
    // ------------------------------------------------------------------
    logic [63:0] data [3];
    logic [2:0]  val_vec;

    assign data[0] = intf_chipset_data_noc1;
    assign data[1] = intf_chipset_data_noc2;
    assign data[2] = intf_chipset_data_noc3;
    assign val_vec = {intf_chipset_val_noc3, intf_chipset_val_noc2, intf_chipset_val_noc1};

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    logic [0:0]           state_reg     [3];
    logic [7:0]           remaining_reg [3];
    logic [CNT_WIDTH-1:0] pkt_reg       [3];
    logic [CNT_WIDTH-1:0] err_reg       [3];
    logic [63:0]          err_hdr_reg   [3];
    logic [IDLE_W-1:0]    idle_reg      [3];
    logic                 seen_reg      [3];
    logic                 flag_reg      [3];

    logic [2:0] complete;   // channel finished a packet this cycle
    logic [2:0] hdr_err;    // channel accepted an erroneous header this cycle

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic       accept;
            logic       in_hdr;
            logic       hdr_take;
            logic       pay_take;
            logic [7:0] len;
            logic [7:0] clamp_len;
            logic       is_err;

            assign accept = val_vec[gi] & en_q;
            assign in_hdr = (state_reg[gi] == ST_HDR);

            // A flit accepted during a clear cycle is dropped entirely.
            assign hdr_take = accept & in_hdr & ~sclr;
            assign pay_take = accept & ~in_hdr & ~sclr;

            assign len       = data[gi][29:22];
            assign clamp_len = (len > MAX_PAYLOAD) ? MAX_PAYLOAD : len;
            assign is_err    = (data[gi][63:50] != EXP_CHIPID)
                            || (data[gi][33:30] != EXP_FBITS)
                            || (data[gi][21:14] != EXP_MSG_TYPE)
                            || (len > MAX_PAYLOAD);

            // Erroneous headers are still framed with the clamped length so
            // the channel stays in step with the generator.
            assign complete[gi] = (hdr_take & (clamp_len == 8'd0))
                                | (pay_take & (remaining_reg[gi] == 8'd1));
            assign hdr_err[gi]  = hdr_take & is_err;

            always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
                if (!chipset_rst_n) begin
                    state_reg[gi]     <= ST_HDR;
                    remaining_reg[gi] <= 8'd0;
                    pkt_reg[gi]       <= '0;
                    err_reg[gi]       <= '0;
                    err_hdr_reg[gi]   <= 64'd0;
                    idle_reg[gi]      <= '0;
                    seen_reg[gi]      <= 1'b0;
                    flag_reg[gi]      <= 1'b0;
                end else if (sclr) begin
                    state_reg[gi]     <= ST_HDR;
                    remaining_reg[gi] <= 8'd0;
                    pkt_reg[gi]       <= '0;
                    err_reg[gi]       <= '0;
                    err_hdr_reg[gi]   <= 64'd0;
                    idle_reg[gi]      <= '0;
                    seen_reg[gi]      <= 1'b0;
                    flag_reg[gi]      <= 1'b0;
                end else begin
                    // Framing
                    if (hdr_take && (clamp_len != 8'd0)) begin
                        remaining_reg[gi] <= clamp_len;
                        state_reg[gi]     <= ST_PAYLOAD;
                    end else if (pay_take) begin
                        remaining_reg[gi] <= remaining_reg[gi] - 8'd1;
                        if (remaining_reg[gi] == 8'd1) begin
                            state_reg[gi] <= ST_HDR;
                        end
                    end

                    // Packet statistics and liveness
                    if (complete[gi]) begin
                        pkt_reg[gi]  <= sat_add(pkt_reg[gi], 2'd1);
                        seen_reg[gi] <= 1'b1;
                        idle_reg[gi] <= '0;
                    end else if (idle_reg[gi] != IDLE_MAX) begin
                        idle_reg[gi] <= idle_reg[gi] + 1'b1;
                    end

                    // Header error statistics
                    if (hdr_err[gi]) begin
                        err_reg[gi]     <= sat_add(err_reg[gi], 2'd1);
                        err_hdr_reg[gi] <= data[gi];
                        flag_reg[gi]    <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Aggregate statistics
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] agg_pkt_reg;
    logic [CNT_WIDTH-1:0] agg_err_reg;
    logic [63:0]          agg_hdr_reg;
    logic [IDLE_W-1:0]    agg_idle_reg;
    logic                 agg_seen_reg;

    logic [1:0]  n_done;
    logic [1:0]  n_err;
    logic [63:0] agg_hdr_next;

    assign n_done = 2'(complete[0]) + 2'(complete[1]) + 2'(complete[2]);
    assign n_err  = 2'(hdr_err[0]) + 2'(hdr_err[1]) + 2'(hdr_err[2]);

    // Lowest-numbered erroring channel wins when several err together.
    always_comb begin
        agg_hdr_next = agg_hdr_reg;
        if (hdr_err[0]) begin
            agg_hdr_next = data[0];
        end else if (hdr_err[1]) begin
            agg_hdr_next = data[1];
        end else if (hdr_err[2]) begin
            agg_hdr_next = data[2];
        end
    end

    always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
        if (!chipset_rst_n) begin
            agg_pkt_reg  <= '0;
            agg_err_reg  <= '0;
            agg_hdr_reg  <= 64'd0;
            agg_idle_reg <= '0;
            agg_seen_reg <= 1'b0;
        end else if (sclr) begin
            agg_pkt_reg  <= '0;
            agg_err_reg  <= '0;
            agg_hdr_reg  <= 64'd0;
            agg_idle_reg <= '0;
            agg_seen_reg <= 1'b0;
        end else begin
            agg_pkt_reg <= sat_add(agg_pkt_reg, n_done);
            agg_err_reg <= sat_add(agg_err_reg, n_err);
            agg_hdr_reg <= agg_hdr_next;
            if (n_done != 2'd0) begin
                agg_idle_reg <= '0;
                agg_seen_reg <= 1'b1;
            end else if (agg_idle_reg != IDLE_MAX) begin
                agg_idle_reg <= agg_idle_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Selected view, registered onto the status outputs
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] view_pkt;
    logic [CNT_WIDTH-1:0] view_err;
    logic [63:0]          view_hdr;
    logic                 view_alive;

    always_comb begin
        view_pkt   = agg_pkt_reg;
        view_err   = agg_err_reg;
        view_hdr   = agg_hdr_reg;
        view_alive = agg_seen_reg && (agg_idle_reg < IDLE_MAX);
        case (sw_debounced)
            2'd0: begin
                view_pkt   = pkt_reg[0];
                view_err   = err_reg[0];
                view_hdr   = err_hdr_reg[0];
                view_alive = seen_reg[0] && (idle_reg[0] < IDLE_MAX);
            end
            2'd1: begin
                view_pkt   = pkt_reg[1];
                view_err   = err_reg[1];
                view_hdr   = err_hdr_reg[1];
                view_alive = seen_reg[1] && (idle_reg[1] < IDLE_MAX);
            end
            2'd2: begin
                view_pkt   = pkt_reg[2];
                view_err   = err_reg[2];
                view_hdr   = err_hdr_reg[2];
                view_alive = seen_reg[2] && (idle_reg[2] < IDLE_MAX);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
        if (!chipset_rst_n) begin
            stat_pkt_count <= '0;
            stat_err_count <= '0;
            stat_err_hdr   <= 64'd0;
            err_flag       <= 3'b000;
            alive          <= 1'b0;
        end else begin
            stat_pkt_count <= view_pkt;
            stat_err_count <= view_err;
            stat_err_hdr   <= view_hdr;
            err_flag       <= {flag_reg[2], flag_reg[1], flag_reg[0]};
            alive          <= view_alive;
        end
    end

endmodule

// File: tb/tb_polara_loopback_checker.sv
// ---------------------------------------------------------------------------
// tb_polara_loopback_checker
//
// Scoreboard bench. A transaction-level model is updated as packets are
// driven, and expected status views are pushed to a queue. The queue is
// drained by selecting each view on sw_debounced and comparing the status
// outputs. A second instance runs with CNT_WIDTH = 4 and TIMEOUT_CYCLES = 16
// on the same inputs. It covers counter saturation and the liveness timeout.
// ---------------------------------------------------------------------------
module tb_polara_loopback_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        chip_rst_n;
    logic        clear;
    logic [1:0]  sw;
    logic [63:0] d1, d2, d3;
    logic [2:0]  v;

    logic        rdy1, rdy2, rdy3;
    logic [31:0] pkt_cnt, err_cnt;
    logic [63:0] err_hdr;
    logic [2:0]  flag;
    logic        alive;

    logic        s_rdy1, s_rdy2, s_rdy3;
    logic [3:0]  s_pkt, s_err;
    logic [63:0] s_hdr;
    logic [2:0]  s_flag;
    logic        s_alive;

    always #5 clk = ~clk;

    polara_loopback_checker u_dut (
        .chipset_clk            (clk),
        .chipset_rst_n          (rst_n),
        .chip_rst_n             (chip_rst_n),
        .clear                  (clear),
        .sw_debounced           (sw),
        .intf_chipset_data_noc1 (d1),
        .intf_chipset_data_noc2 (d2),
        .intf_chipset_data_noc3 (d3),
        .intf_chipset_val_noc1  (v[0]),
        .intf_chipset_val_noc2  (v[1]),
        .intf_chipset_val_noc3  (v[2]),
        .intf_chipset_rdy_noc1  (rdy1),
        .intf_chipset_rdy_noc2  (rdy2),
        .intf_chipset_rdy_noc3  (rdy3),
        .stat_pkt_count         (pkt_cnt),
        .stat_err_count         (err_cnt),
        .stat_err_hdr           (err_hdr),
        .err_flag               (flag),
        .alive                  (alive)
    );

    polara_loopback_checker #(
        .CNT_WIDTH      (4),
        .TIMEOUT_CYCLES (16)
    ) u_small (
        .chipset_clk            (clk),
        .chipset_rst_n          (rst_n),
        .chip_rst_n             (chip_rst_n),
        .clear                  (clear),
        .sw_debounced           (sw),
        .intf_chipset_data_noc1 (d1),
        .intf_chipset_data_noc2 (d2),
        .intf_chipset_data_noc3 (d3),
        .intf_chipset_val_noc1  (v[0]),
        .intf_chipset_val_noc2  (v[1]),
        .intf_chipset_val_noc3  (v[2]),
        .intf_chipset_rdy_noc1  (s_rdy1),
        .intf_chipset_rdy_noc2  (s_rdy2),
        .intf_chipset_rdy_noc3  (s_rdy3),
        .stat_pkt_count         (s_pkt),
        .stat_err_count         (s_err),
        .stat_err_hdr           (s_hdr),
        .err_flag               (s_flag),
        .alive                  (s_alive)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model (transaction level)
    // ------------------------------------------------------------------
    int          m_pkt  [4];
    int          m_err  [4];
    logic [63:0] m_hdr  [4];
    logic        m_seen [4];
    logic [2:0]  m_flag;

    function automatic logic [63:0] mk_hdr(input logic [13:0] cid, input logic [3:0] fb,
                                           input logic [7:0] len, input logic [7:0] mt);
        return {cid, 8'h12, 8'h34, fb, len, mt, 8'h56, 6'h00};
    endfunction

    function automatic logic [63:0] good_hdr(input logic [7:0] len);
        return mk_hdr(14'h2000, 4'b0010, len, 8'd18);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_pkt[i]  = 0;
            m_err[i]  = 0;
            m_hdr[i]  = 64'd0;
            m_seen[i] = 1'b0;
        end
        m_flag = 3'b000;
    endtask

    // For simultaneous packets call from highest to lowest channel, so the
    // aggregate header ends up as the lowest-numbered erroring one.
    task automatic model_pkt(input int ch, input logic [63:0] h);
        logic e;
        e = (h[63:50] != 14'h2000) || (h[33:30] != 4'b0010)
         || (h[21:14] != 8'd18)    || (h[29:22] > 8'd8);
        m_pkt[ch]++;
        m_pkt[3]++;
        m_seen[ch] = 1'b1;
        m_seen[3]  = 1'b1;
        if (e) begin
            m_err[ch]++;
            m_err[3]++;
            m_hdr[ch]  = h;
            m_hdr[3]   = h;
            m_flag[ch] = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        string       tag;
        int          dut;
        logic [1:0]  sel;
        logic [63:0] pkt;
        logic [63:0] err;
        logic [63:0] hdr;
        logic [2:0]  flag;
        logic        alv;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input string tag, input int dut, input int sel, input int pkt,
                            input int err, input logic [63:0] hdr, input logic [2:0] fl,
                            input logic alv);
        exp_t e;
        e.tag  = tag;
        e.dut  = dut;
        e.sel  = 2'(sel);
        e.pkt  = 64'(pkt);
        e.err  = 64'(err);
        e.hdr  = hdr;
        e.flag = fl;
        e.alv  = alv;
        sb.push_back(e);
    endtask

    task automatic push_view(input string tag, input int sel);
        push_exp(tag, 0, sel, m_pkt[sel], m_err[sel], m_hdr[sel], m_flag, m_seen[sel]);
    endtask

    task automatic drain();
        exp_t        e;
        logic [63:0] g_pkt, g_err, g_hdr;
        logic [2:0]  g_flag;
        logic        g_alv;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            sw = e.sel;
            repeat (2) @(negedge clk);
            if (e.dut == 0) begin
                g_pkt = 64'(pkt_cnt); g_err = 64'(err_cnt); g_hdr = err_hdr;
                g_flag = flag; g_alv = alive;
            end else begin
                g_pkt = 64'(s_pkt); g_err = 64'(s_err); g_hdr = s_hdr;
                g_flag = s_flag; g_alv = s_alive;
            end
            $display("[%0t] %s dut=%0d sel=%0d pkt=%0d err=%0d flag=%b alive=%b",
                     $time, e.tag, e.dut, e.sel, g_pkt, g_err, g_flag, g_alv);
            check_value({e.tag, "_pkt"},   g_pkt,        e.pkt);
            check_value({e.tag, "_err"},   g_err,        e.err);
            check_value({e.tag, "_hdr"},   g_hdr,        e.hdr);
            check_value({e.tag, "_flag"},  64'(g_flag),  64'(e.flag));
            check_value({e.tag, "_alive"}, 64'(g_alv),   64'(e.alv));
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive3(input logic [2:0] m, input logic [63:0] f1,
                          input logic [63:0] f2, input logic [63:0] f3);
        @(negedge clk);
        d1 = f1; d2 = f2; d3 = f3;
        v  = m;
    endtask

    task automatic drive_all(input logic [2:0] m, input logic [63:0] f);
        drive3(m, f, f, f);
    endtask

    task automatic release_bus();
        @(negedge clk);
        v = 3'b000;
    endtask

    task automatic payload(input logic [2:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            drive_all(m, {$urandom, $urandom});
        end
    endtask

    task automatic wait_rdy();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy1 && rdy2 && rdy3 && s_rdy1) begin
                ok = 1'b1;
                break;
            end
        end
        check_value("rdy_wait", 64'(ok), 64'd1);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    logic [63:0] h_a, h_b, h_c;

    initial begin
        rst_n      = 1'b0;
        chip_rst_n = 1'b1;
        clear      = 1'b0;
        sw         = 2'd0;
        d1 = 64'd0; d2 = 64'd0; d3 = 64'd0;
        v  = 3'b000;
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        check_value("rst_rdy",   64'({rdy3, rdy2, rdy1}), 64'd0);
        check_value("rst_pkt",   64'(pkt_cnt), 64'd0);
        check_value("rst_err",   64'(err_cnt), 64'd0);
        check_value("rst_hdr",   err_hdr,      64'd0);
        check_value("rst_flag",  64'(flag),    64'd0);
        check_value("rst_alive", 64'(alive),   64'd0);

        // Ready rises on the second edge after reset release
        rst_n = 1'b1;
        @(negedge clk);
        check_value("rdy_edge1", 64'(rdy1), 64'd0);
        @(negedge clk);
        check_value("rdy_edge2", 64'(rdy1), 64'd1);

        // Five valid LEN=0 headers on noc1, back to back
        wait_rdy();
        for (int i = 0; i < 5; i++) begin
            drive_all(3'b001, good_hdr(8'd0));
            model_pkt(0, good_hdr(8'd0));
        end
        release_bus();
        push_view("noc1_len0", 0);
        drain();

        // noc2 header with wrong MSG TYPE, LEN=2, then two payload flits
        h_a = mk_hdr(14'h2000, 4'b0010, 8'd2, 8'd19);
        wait_rdy();
        drive3(3'b010, 64'd0, h_a, 64'd0);
        payload(3'b010, 2);
        release_bus();
        model_pkt(1, h_a);
        push_view("noc2_msgerr", 1);
        push_view("agg_after_noc2", 3);
        drain();

        // Clear, then all views must read zero
        pulse_clear();
        for (int s = 0; s < 4; s++) push_view($sformatf("clr_view%0d", s), s);
        drain();

        // A valid 3-flit packet on all three channels at once
        wait_rdy();
        drive_all(3'b111, good_hdr(8'd2));
        payload(3'b111, 2);
        release_bus();
        for (int c = 2; c >= 0; c--) model_pkt(c, good_hdr(8'd2));
        for (int s = 3; s >= 0; s--) push_view($sformatf("sim3_view%0d", s), s);
        drain();

        // Oversized LEN on noc3 is framed with MAX_PAYLOAD, then a LEN=0
        // header immediately after must be seen as a header
        h_b = mk_hdr(14'h2000, 4'b0010, 8'd20, 8'd18);
        wait_rdy();
        drive3(3'b100, 64'd0, 64'd0, h_b);
        payload(3'b100, 8);
        drive3(3'b100, 64'd0, 64'd0, good_hdr(8'd0));
        release_bus();
        model_pkt(2, h_b);
        model_pkt(2, good_hdr(8'd0));

        // Simultaneous errors on noc2 (CHIPID) and noc3 (FBITS), noc1 good
        h_a = mk_hdr(14'h0001, 4'b0010, 8'd0, 8'd18);
        h_c = mk_hdr(14'h2000, 4'b0111, 8'd0, 8'd18);
        drive3(3'b111, good_hdr(8'd0), h_a, h_c);
        release_bus();
        model_pkt(2, h_c);
        model_pkt(1, h_a);
        model_pkt(0, good_hdr(8'd0));
        push_view("multi_agg", 3);
        push_view("multi_noc2", 1);
        push_view("multi_noc3", 2);
        drain();

        // chip_rst_n pulsed low on the second of four payload flits on noc3
        wait_rdy();
        drive3(3'b100, 64'd0, 64'd0, good_hdr(8'd4));
        payload(3'b100, 1);
        @(negedge clk);
        d3 = {$urandom, $urandom};
        v  = 3'b100;
        chip_rst_n = 1'b0;
        @(negedge clk);
        chip_rst_n = 1'b1;
        v = 3'b000;
        check_value("chiprst_rdy_hold", 64'(rdy3), 64'd1);
        @(negedge clk);
        check_value("chiprst_rdy_drop", 64'(rdy3), 64'd0);
        model_clear();
        push_view("chiprst_noc3", 2);
        push_view("chiprst_agg", 3);
        drain();
        wait_rdy();
        drive3(3'b100, 64'd0, 64'd0, good_hdr(8'd0));
        release_bus();
        model_pkt(2, good_hdr(8'd0));
        push_view("after_chiprst", 2);
        drain();

        // clear in the same cycle as an accepted header
        wait_rdy();
        @(negedge clk);
        d1 = good_hdr(8'd0);
        v  = 3'b001;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        v = 3'b000;
        model_clear();
        push_view("clr_same_noc1", 0);
        push_view("clr_same_agg", 3);
        drain();

        // 17 back-to-back packets: 32-bit counts 17, 4-bit counts pin at 15
        wait_rdy();
        for (int i = 0; i < 17; i++) begin
            drive_all(3'b001, good_hdr(8'd0));
            model_pkt(0, good_hdr(8'd0));
        end
        release_bus();
        push_view("sat_main", 0);
        push_exp("sat_small", 1, 0, 15, 0, 64'd0, 3'b000, 1'b1);
        push_exp("sat_small_agg", 1, 3, 15, 0, 64'd0, 3'b000, 1'b1);
        drain();

        // Idle past the short timeout: small instance goes not-alive
        repeat (20) @(negedge clk);
        push_exp("timeout_small", 1, 0, 15, 0, 64'd0, 3'b000, 1'b0);
        push_exp("timeout_small_agg", 1, 3, 15, 0, 64'd0, 3'b000, 1'b0);
        push_view("timeout_main", 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
